io_port_unit: RTL

- Responder side of the accumulator-machine I/O instruction group (INP, OUT, SKI, SKO, ION, IOF). The controller decodes these but does not execute them; this block does.
- Holds the input buffer INPR and input flag FGI, the output buffer OUTR and output flag FGO, the interrupt enable IEN and the interrupt request R.
- Controller side: one-hot op strobes in; input data, skip condition and interrupt request out.
- Device side: valid/ready handshakes to a keyboard source and a printer sink, with a modelled printer busy time.

---
 rtl/io_port_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/io_port_unit.sv
// I/O responder for the accumulator machine: INP/OUT/SKI/SKO/ION/IOF,
// keyboard and printer handshakes, interrupt request flip-flop.
module io_port_unit #(
  parameter int WIDTH     = 8,
  parameter int PRINT_DLY = 4
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             IO_EN,
  input  logic [5:0]       IO_OP,
  input  logic [WIDTH-1:0] AC_LOW,
  input  logic             INT_ACK,
  output logic [WIDTH-1:0] INPR_OUT,
  output logic             SKIP,
  output logic             IRQ,
  output logic             FGI,
  output logic             FGO,
  input  logic [WIDTH-1:0] RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic [WIDTH-1:0] TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    BUSY
  } tx_st_t;

  localparam logic [7:0] DLY_M1 =
    (PRINT_DLY > 0) ? 8'(PRINT_DLY - 1) : 8'd0;

  logic [WIDTH-1:0] inpr;
  logic [WIDTH-1:0] outr;
  logic             fgi_q;
  logic             fgo_q;
  logic             ien;
  logic             r_q;
  tx_st_t           tx_st;
  logic [7:0]       cnt;

  logic [5:0] sel;
  logic do_inp, do_out, do_ski;
  logic do_sko, do_ion, do_iof;
  logic rx_fire;

  // Highest set op bit wins; sel is one-hot or zero.
  assign sel[5] = IO_EN & IO_OP[5];
  assign sel[4] = IO_EN & IO_OP[4] & ~IO_OP[5];
  assign sel[3] = IO_EN & IO_OP[3] & ~|IO_OP[5:4];
  assign sel[2] = IO_EN & IO_OP[2] & ~|IO_OP[5:3];
  assign sel[1] = IO_EN & IO_OP[1] & ~|IO_OP[5:2];
  assign sel[0] = IO_EN & IO_OP[0] & ~|IO_OP[5:1];

  always_comb begin
    do_inp = 1'b0;
    do_out = 1'b0;
    do_ski = 1'b0;
    do_sko = 1'b0;
    do_ion = 1'b0;
    do_iof = 1'b0;
    unique case (1'b1)
      sel[5]:  do_inp = 1'b1;
      sel[4]:  do_out = 1'b1;
      sel[3]:  do_ski = 1'b1;
      sel[2]:  do_sko = 1'b1;
      sel[1]:  do_ion = 1'b1;
      sel[0]:  do_iof = 1'b1;
      default: ;
    endcase
  end

  assign rx_fire  = RX_VALID & ~fgi_q;
  assign RX_READY = ~fgi_q;
  assign INPR_OUT = inpr;
  assign TX_DATA  = outr;
  assign TX_VALID = (tx_st == SEND);
  assign FGI      = fgi_q;
  assign FGO      = fgo_q;
  assign IRQ      = r_q;
  assign SKIP     = (do_ski & fgi_q) | (do_sko & fgo_q);

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      inpr  <= '0;
      outr  <= '0;
      fgi_q <= 1'b0;
      fgo_q <= 1'b1;
      ien   <= 1'b0;
      r_q   <= 1'b0;
      tx_st <= IDLE;
      cnt   <= 8'd0;
    end else begin
      if (rx_fire) begin
        inpr  <= RX_DATA;
        fgi_q <= 1'b1;
      end else if (do_inp) begin
        fgi_q <= 1'b0;
      end

      if (INT_ACK) begin
        r_q <= 1'b0;
        ien <= 1'b0;
      end else begin
        if (do_ion)
          ien <= 1'b1;
        else if (do_iof)
          ien <= 1'b0;
        if (ien & (fgi_q | fgo_q))
          r_q <= 1'b1;
      end

      // FGO=1 only ever coexists with IDLE.
      unique case (tx_st)
        IDLE: begin
          if (do_out && fgo_q) begin
            outr  <= AC_LOW;
            fgo_q <= 1'b0;
            tx_st <= SEND;
          end
        end
        SEND: begin
          if (TX_READY) begin
            if (PRINT_DLY > 0) begin
              cnt   <= DLY_M1;
              tx_st <= BUSY;
            end else begin
              fgo_q <= 1'b1;
              tx_st <= IDLE;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            fgo_q <= 1'b1;
            tx_st <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

endmodule
